// File: rtl/serial_arith_pkg.sv
// Shared encodings for the digit-serial adder/subtractor.
// Operation modes and control-state values live here.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_ADDC = 2'd1,
        MODE_SUB  = 2'd2,
        MODE_RSUB = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_addsub_pipe_if.sv
// Request/result handshake bundle for serial_addsub_pipe.
// master drives requests and consumes results; slave is the block.
interface serial_addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, mode, cin, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, mode, cin, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder.
// Also exposes the carry into its top bit for overflow detection.
module serial_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] w_c;

    // Ripple the carry through each bit of the digit
    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];
endmodule

// File: rtl/serial_addsub_pipe.sv
// Digit-serial add/subtract unit, WIDTH/DIGIT cycles per operation.
// Operands are latched on accept and consumed LSB digit first.
module serial_addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_pipe_if.slave  bus,
    output logic                 busy
);
    import serial_arith_pkg::*;

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH
        || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_addsub_pipe: bad WIDTH/DIGIT");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_load;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic             w_dcmsb;
    logic [WIDTH-1:0] w_sum_shift;

    assign w_in_ready = (r_state == IDLE)
                     || (r_state == DONE && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_cnt == CNT_W'(NDIG - 1));

    // Map the requested mode onto a plain add of (a_reg + b_reg + carry)
    always_comb begin
        w_a_load = bus.a;
        w_b_load = bus.b;
        w_c_load = 1'b0;
        unique case (mode_e'(bus.mode))
            MODE_ADD: begin
                w_c_load = 1'b0;
            end
            MODE_ADDC: begin
                w_c_load = bus.cin;
            end
            MODE_SUB: begin
                w_b_load = ~bus.b;
                w_c_load = 1'b1;
            end
            MODE_RSUB: begin
                w_a_load = bus.b;
                w_b_load = ~bus.a;
                w_c_load = 1'b1;
            end
        endcase
    end

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .sum   (w_dsum),
        .cout  (w_dcout),
        .c_msb (w_dcmsb)
    );

    if (DIGIT == WIDTH) begin : g_full
        assign w_sum_shift = w_dsum;
    end else begin : g_part
        assign w_sum_shift = {w_dsum, r_sum[WIDTH-1:DIGIT]};
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: DONE may hand straight over to a new ADD
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = ADD;
            end
            ADD: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = w_accept ? ADD : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand load on accept, then one digit per cycle while in ADD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_carry <= w_c_load;
            r_a     <= w_a_load;
            r_b     <= w_b_load;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == ADD) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_shift;
            r_carry <= w_dcout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_dcout;
                r_ovf  <= w_dcmsb ^ w_dcout;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign busy          = (r_state == ADD);
endmodule

// File: tb/tb_serial_addsub_pipe.sv
// Scoreboard bench: an 8-bit/1-bit and a 16-bit/4-bit instance.
// Expected results are queued at issue and popped by per-DUT monitors.
module tb_serial_addsub_pipe;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst8;
    logic rst16;
    logic busy8;
    logic busy16;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8;
    exp_t e16;

    serial_addsub_pipe_if #(.WIDTH(8))  bus8 ();
    serial_addsub_pipe_if #(.WIDTH(16)) bus16 ();

    serial_addsub_pipe #(
        .WIDTH (8),
        .DIGIT (1)
    ) u8 (
        .clk  (clk),
        .rst  (rst8),
        .bus  (bus8.slave),
        .busy (busy8)
    );

    serial_addsub_pipe #(
        .WIDTH (16),
        .DIGIT (4)
    ) u16 (
        .clk  (clk),
        .rst  (rst16),
        .bus  (bus16.slave),
        .busy (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Monitor for the 8-bit instance: compare on each result handshake
    always @(negedge clk) begin
        if (bus8.out_valid && bus8.out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u8_unexpected actual=0x%0h required=none",
                         bus8.sum);
            end else begin
                e8 = q8.pop_front();
                chk("u8_sum", 32'(bus8.sum), 32'(e8.sum));
                chk("u8_cout", 32'(bus8.cout), 32'(e8.cout));
                chk("u8_ovf", 32'(bus8.ovf), 32'(e8.ovf));
            end
        end
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u16_unexpected actual=0x%0h required=none",
                         bus16.sum);
            end else begin
                e16 = q16.pop_front();
                chk("u16_sum", 32'(bus16.sum), 32'(e16.sum));
                chk("u16_cout", 32'(bus16.cout), 32'(e16.cout));
                chk("u16_ovf", 32'(bus16.ovf), 32'(e16.ovf));
            end
        end
    end

    task automatic req8(input logic push, input logic [1:0] m,
                        input logic c, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] es,
                        input logic ec, input logic eo,
                        output int waited);
        exp_t e;
        int   n;
        bus8.mode     = m;
        bus8.cin      = c;
        bus8.a        = a;
        bus8.b        = b;
        bus8.in_valid = 1'b1;
        if (push) begin
            e.sum  = {8'h00, es};
            e.cout = ec;
            e.ovf  = eo;
            q8.push_back(e);
        end
        n = 0;
        @(negedge clk);
        while (!bus8.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.in_ready) chk("u8_accept_timeout", 0, 1);
        waited = n;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic req16(input logic [1:0] m, input logic c,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] es, input logic ec,
                         input logic eo, output int waited);
        exp_t e;
        int   n;
        bus16.mode     = m;
        bus16.cin      = c;
        bus16.a        = a;
        bus16.b        = b;
        bus16.in_valid = 1'b1;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        q16.push_back(e);
        n = 0;
        @(negedge clk);
        while (!bus16.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus16.in_ready) chk("u16_accept_timeout", 0, 1);
        waited = n;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (q8.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q8.size() != 0) chk("u8_drain_timeout", 32'(q8.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain16();
        int n;
        n = 0;
        while (q16.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q16.size() != 0) chk("u16_drain_timeout", 32'(q16.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n;
        rst8            = 1'b0;
        rst16           = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.mode       = 2'd0;
        bus8.cin        = 1'b0;
        bus8.a          = 8'h00;
        bus8.b          = 8'h00;
        bus8.out_ready  = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.mode      = 2'd0;
        bus16.cin       = 1'b0;
        bus16.a         = 16'h0000;
        bus16.b         = 16'h0000;
        bus16.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus8.out_valid), 0);
        chk("rst_sum", 32'(bus8.sum), 0);
        chk("rst_cout", 32'(bus8.cout), 0);
        chk("rst_ovf", 32'(bus8.ovf), 0);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_in_ready", 32'(bus8.in_ready), 1);
        chk("rst16_sum", 32'(bus16.sum), 0);
        chk("rst16_out_valid", 32'(bus16.out_valid), 0);
        @(posedge clk);
        #1;
        rst8           = 1'b1;
        rst16          = 1'b1;
        bus8.out_ready = 1'b1;

        req8(1, 2'd0, 0, 8'h3C, 8'h5A, 8'h96, 0, 1, w);
        n = 0;
        while (!bus8.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u8_latency", 32'(n), 8);
        drain8();

        req8(1, 2'd2, 0, 8'h10, 8'h20, 8'hF0, 0, 0, w);
        req8(1, 2'd3, 0, 8'h10, 8'h20, 8'h10, 1, 0, w);
        req8(1, 2'd1, 1, 8'hFF, 8'h00, 8'h00, 1, 0, w);
        req8(1, 2'd1, 0, 8'hFF, 8'h00, 8'hFF, 0, 0, w);
        req8(1, 2'd1, 1, 8'h7F, 8'h00, 8'h80, 0, 1, w);
        drain8();

        req8(1, 2'd0, 0, 8'h80, 8'h80, 8'h00, 1, 1, w);
        for (int k = 0; k < 6; k++) begin
            bus8.a        = 8'($urandom);
            bus8.b        = 8'($urandom);
            bus8.mode     = 2'($urandom_range(3, 0));
            bus8.cin      = 1'($urandom_range(1, 0));
            bus8.in_valid = (k >= 1 && k <= 3);
            @(negedge clk);
            if (bus8.in_valid) begin
                chk("u8_busy_in_ready", 32'(bus8.in_ready), 0);
                chk("u8_busy", 32'(busy8), 1);
            end
            @(posedge clk);
            #1;
        end
        bus8.in_valid = 1'b0;
        drain8();

        req8(1, 2'd2, 0, 8'h80, 8'h01, 8'h7F, 1, 1, w);
        drain8();

        req8(0, 2'd0, 0, 8'hAA, 8'h55, 8'h00, 0, 0, w);
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus8.out_valid), 0);
        chk("abort_sum", 32'(bus8.sum), 0);
        chk("abort_cout", 32'(bus8.cout), 0);
        chk("abort_ovf", 32'(bus8.ovf), 0);
        chk("abort_busy", 32'(busy8), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_hold_sum", 32'(bus8.sum), 0);
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy8), 0);
        chk("post_rst_valid", 32'(bus8.out_valid), 0);
        @(posedge clk);
        #1;
        req8(1, 2'd0, 0, 8'h01, 8'h01, 8'h02, 0, 0, w);
        drain8();

        req16(2'd0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, w);
        n = 0;
        while (!bus16.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u16_latency", 32'(n), 4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("u16_hold_valid", 32'(bus16.out_valid), 1);
            chk("u16_hold_sum", 32'(bus16.sum), 32'h8000);
            chk("u16_hold_ovf", 32'(bus16.ovf), 1);
            chk("u16_hold_cout", 32'(bus16.cout), 0);
            @(posedge clk);
            #1;
        end
        bus16.out_ready = 1'b1;
        req16(2'd2, 0, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, w);
        chk("u16_b2b_wait", 32'(w), 0);
        chk("u16_b2b_busy", 32'(busy16), 1);
        chk("u16_b2b_valid", 32'(bus16.out_valid), 0);
        drain16();

        repeat (4) @(posedge clk);
        chk("q8_empty", 32'(q8.size()), 0);
        chk("q16_empty", 32'(q16.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
